// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS control unit: main-control FSM with Moore output decode,
// program counter with optional wrap back to the reset vector, and a
// retired-instruction counter. Memory states can stall on a ready handshake.
module mc_ctrl_unit #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0004,
  parameter bit              MEM_HANDSHAKE = 1'b1,
  parameter bit              WRAP_EN       = 1'b1,
  parameter logic [XLEN-1:0] WRAP_PC       = 32'h0000_0024,
  parameter int              CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [25:0]      jaddr,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  alu_out,
  output logic [XLEN-1:0]  pc,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0]       r_state;
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_instr_count;
  logic             r_illegal;

  logic [3:0]       w_next_state;
  logic             w_done;
  logic             w_retire;
  logic             w_illegal_det;
  logic             w_pc_upd;
  logic [XLEN-1:0]  w_npc;
  logic [XLEN-1:0]  w_pc_next;

  // Without the handshake every memory access completes in its first cycle.
  assign w_done = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Next-state selection, retire and illegal-opcode detection.
  always_comb begin
    w_next_state  = r_state;
    w_retire      = 1'b0;
    w_illegal_det = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_done) w_next_state = S_DECODE;
        else        w_next_state = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default: begin
            w_next_state  = S_FETCH;
            w_illegal_det = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) w_next_state = S_MEMRD;
        else                 w_next_state = S_MEMWR;
      end
      S_MEMRD: begin
        if (w_done) w_next_state = S_MEMWB;
        else        w_next_state = S_MEMRD;
      end
      S_MEMWR: begin
        if (w_done) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_EXEC:   w_next_state = S_ALUWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // Candidate PC: at most one source per cycle, then the wrap substitution.
  always_comb begin
    w_pc_upd = 1'b0;
    w_npc    = r_pc;
    if ((r_state == S_FETCH) && w_done) begin
      w_pc_upd = 1'b1;
      w_npc    = alu_result;
    end else if ((r_state == S_BRANCH) && zero) begin
      w_pc_upd = 1'b1;
      w_npc    = alu_out;
    end else if (r_state == S_JUMP) begin
      w_pc_upd = 1'b1;
      w_npc    = {r_pc[XLEN-1:28], jaddr, 2'b00};
    end else begin
      w_pc_upd = 1'b0;
      w_npc    = r_pc;
    end
    if (WRAP_EN && (w_npc == WRAP_PC)) w_pc_next = RESET_PC;
    else                               w_pc_next = w_npc;
  end

  // State, PC, counter and illegal pulse; reset wins over any pending wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_instr_count <= {CNT_W{1'b0}};
      r_illegal     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_illegal <= w_illegal_det;
      if (w_pc_upd) r_pc <= w_pc_next;
      if (w_retire) r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Moore decode of the datapath controls from the current state.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (r_state)
      S_FETCH:  begin mem_req = 1'b1; alu_src_b = 2'b01; end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:  begin mem_req = 1'b1; iord = 1'b1; end
      S_MEMWR:  begin mem_req = 1'b1; iord = 1'b1; mem_we = 1'b1; end
      S_MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_EXEC:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_ALUWB:  begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_BRANCH: begin alu_src_a = 1'b1; alu_op = 2'b01; end
      S_ADDIWB: reg_write = 1'b1;
      default:  mem_req = 1'b0;
    endcase
  end

  assign ir_write    = (r_state == S_FETCH) && w_done;
  assign pc          = r_pc;
  assign state       = r_state;
  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

endmodule

// File: doc/mc_ctrl_unit.md
Name: mc_ctrl_unit

Overview:
- Parametrised multicycle MIPS control unit: main-control FSM, PC register and retired-instruction counter in one block.
- Drives the multicycle datapath: register file, ALU, IR/data/A/B/ALUOut flops and the shared instruction/data memory.
- Adds three features over the previous controller:
  - variable-latency memory handshake;
  - parametrised reset vector and PC wrap;
  - illegal-opcode detection.

Parameters:
XLEN, 32, datapath/PC width; legal values ≥32.
RESET_PC, 32'h0000_0004, PC value loaded on reset and on wrap.
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored, each access takes 1 cycle.
WRAP_EN, 1, 1: enable PC wrap.
WRAP_PC, 32'h0000_0024, a PC update equal to this value loads RESET_PC instead.
CNT_W, 16, retired-instruction counter width.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  reset, synchronous, active-high.
opcode  in  6  Instr[31:26] from IR.
jaddr  in  26  Instr[25:0] from IR.
zero  in  1  ALU zero flag, same-cycle.
mem_ready  in  1  memory access complete this cycle.
alu_result  in  XLEN  combinational ALU output.
alu_out  in  XLEN  registered ALUOut.
pc  out  XLEN  program counter.
mem_req  out  1  memory access request.
mem_we  out  1  memory write enable.
iord  out  1  0 = address from PC, 1 = address from ALUOut.
ir_write  out  1  IR load enable.
reg_write  out  1  register-file write enable.
reg_dst  out  1  1 = rd, 0 = rt.
mem_to_reg  out  1  1 = write-back from Data, 0 = from ALUOut.
alu_src_a  out  1  0 = PC, 1 = A.
alu_src_b  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
alu_op  out  2  00 = add, 01 = sub, 10 = funct.
state  out  4  current FSM state code.
illegal  out  1  one-cycle pulse on an unknown opcode.
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset: state = FETCH(0), pc = RESET_PC, instr_count = 0, illegal = 0. Reset overrides everything, including mid-instruction and a pending memory wait.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Outputs are Moore decodes of state; any signal not listed below is 0.
  - FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00. These are also the output values immediately after reset.
  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut).
  - MEMADR and ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - MEMRD: mem_req = 1, iord = 1.
  - MEMWR: mem_req = 1, iord = 1, mem_we = 1.
  - MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1.
  - EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01.
  - ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
  - JUMP: no control outputs asserted.
- Memory done condition: done = mem_ready when MEM_HANDSHAKE = 1, else done = 1. FETCH, MEMRD and MEMWR hold (outputs stable) while !done.
- ir_write = (state == FETCH) && done. It is the only gated output.
- Transitions:
  - FETCH → DECODE on done.
  - DECODE, by opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXEC
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - any other opcode → FETCH, with illegal = 1 for that one cycle.
  - MEMADR → MEMRD for lw, → MEMWR for sw.
  - MEMRD → MEMWB on done.
  - EXEC → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWR (on done), MEMWB, ALUWB, BRANCH, ADDIWB and JUMP → FETCH. These exits retire the instruction: instr_count += 1.
  - An illegal opcode does not retire.
- PC update, at most one per cycle:
  - FETCH && done: npc = alu_result (PC+4).
  - BRANCH && zero: npc = alu_out.
  - JUMP: npc = {pc[XLEN-1:28], jaddr, 2'b00}.
- Wrap: if WRAP_EN and npc == WRAP_PC, pc <= RESET_PC; otherwise pc <= npc. Wrap applies to every update source.
- Opcode is sampled only in DECODE and MEMADR; it is assumed stable there because IR loads only in FETCH.

Test Plan:
- MEM_HANDSHAKE = 0, lw at pc = 4: states 0,1,2,3,4,0 in 5 cycles; ir_write high in cycle 1 only; pc = 8 after FETCH; reg_write = 1 and mem_to_reg = 1 in MEMWB; instr_count = 1.
- MEM_HANDSHAKE = 1, mem_ready held low 3 cycles in FETCH, then in MEMWR (sw): state holds at 0 and 5; mem_we stays high through the wait; ir_write and the pc update occur only on the mem_ready cycle.
- beq with zero = 1, alu_out = 0x40: pc = 0x40 after BRANCH. Same with zero = 0: pc stays at PC+4. Both increment instr_count.
- WRAP_PC = 0x24: FETCH at pc = 0x20 with alu_result = 0x24 → pc = RESET_PC (0x4). j with jaddr = 0x9 (target 0x24) → pc = 0x4. With WRAP_EN = 0 → pc = 0x24.
- Opcode 6'b111111: DECODE → FETCH; illegal high exactly 1 cycle; instr_count unchanged; pc already advanced.
- rst asserted in MEMRD while mem_ready is low: next cycle state = 0, pc = RESET_PC, instr_count = 0, illegal = 0, mem_req = 1, iord = 0.
